// File: rtl/f_add_arbiter.sv
// f_add_arbiter: round-robin arbiter that lets N_REQ requesters share one
// f_add unit. Grants are combinational, operands are issued one cycle after
// the transfer, and returning results are routed back to their owner through
// an in-order tag FIFO of depth MAX_OUT.
// Optional feature: define F_ADD_ARB_STATS_EN to enable the issue/stall
// statistics counters; otherwise both stat ports are tied to zero.
module f_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int FLEN    = 64,
    parameter int MAX_OUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*FLEN-1:0] req_a,
    input  logic [N_REQ*FLEN-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [FLEN-1:0]       resp_res,
    output logic                  resp_error,
    output logic                  fu_up_valid,
    output logic [FLEN-1:0]       fu_a,
    output logic [FLEN-1:0]       fu_b,
    input  logic [FLEN-1:0]       fu_res,
    input  logic                  fu_down_valid,
    input  logic                  fu_busy,
    input  logic                  fu_error,
    output logic                  err_unexpected,
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_stalled
);

    localparam int IDX_W = $clog2(N_REQ);
    // Pointers are at least one bit wide; the FIFO storage rounds up to a
    // power of two so the pointers wrap naturally.
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int DEPTH = 2 ** PTR_W;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [N_REQ-1:0] grant_oh;
    logic             found;
    logic             pop;
    logic             issue_ok;
    logic             transfer;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] tag_mem [DEPTH];

    // A result only pops the tag FIFO when something is actually outstanding.
    assign pop = fu_down_valid && (count != '0);

    // Issue needs a free unit and a free slot; a same-cycle pop frees a slot
    // even when the count is at its limit.
    assign issue_ok = rst && !fu_busy && ((count != CNT_FULL) || pop);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        grant_oh  = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found          = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

    assign req_ready = issue_ok ? grant_oh : '0;
    assign transfer  = issue_ok && found;

    // Control state: issue strobe, response strobe, tag pointers, count, error flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            last_grant     <= LAST_IDX;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fu_up_valid    <= 1'b0;
            resp_valid     <= '0;
            resp_error     <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            fu_up_valid <= transfer;
            resp_valid  <= pop ? (N_REQ'(1) << tag_mem[rd_ptr]) : '0;
            resp_error  <= pop && fu_error;

            if (transfer) begin
                last_grant <= grant_idx;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (transfer && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !transfer) begin
                count <= count - 1'b1;
            end

            if (fu_down_valid && (count == '0)) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    // Datapath: tag storage, issued operands and returned result.
    always_ff @(posedge clk) begin
        // NOTE: tag storage and data registers carry no reset; the pointers and
        // count alone decide which entries and values are meaningful.
        if (transfer) begin
            tag_mem[wr_ptr] <= grant_idx;
            fu_a            <= req_a[grant_idx*FLEN +: FLEN];
            fu_b            <= req_b[grant_idx*FLEN +: FLEN];
        end
        if (pop) begin
            resp_res <= fu_res;
        end
    end

`ifdef F_ADD_ARB_STATS_EN
    // Statistics: transfers, and cycles where someone asked but nothing issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_issued  <= '0;
            stat_stalled <= '0;
        end else begin
            if (transfer) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if ((|req_valid) && !transfer) begin
                stat_stalled <= stat_stalled + 32'd1;
            end
        end
    end
`else
    assign stat_issued  = '0;
    assign stat_stalled = '0;
`endif

endmodule

// File: tb/tb_f_add_arbiter.sv
// Directed self-checking bench for f_add_arbiter with default parameters
// (4 requesters, 64-bit operands, 8 outstanding operations).
module tb_f_add_arbiter;

    localparam int N_REQ   = 4;
    localparam int FLEN    = 64;
    localparam int MAX_OUT = 8;

    logic                  clk;
    logic                  rst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*FLEN-1:0] req_a;
    logic [N_REQ*FLEN-1:0] req_b;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      resp_valid;
    logic [FLEN-1:0]       resp_res;
    logic                  resp_error;
    logic                  fu_up_valid;
    logic [FLEN-1:0]       fu_a;
    logic [FLEN-1:0]       fu_b;
    logic [FLEN-1:0]       fu_res;
    logic                  fu_down_valid;
    logic                  fu_busy;
    logic                  fu_error;
    logic                  err_unexpected;
    logic [31:0]           stat_issued;
    logic [31:0]           stat_stalled;

    int checks   = 0;
    int failures = 0;

    f_add_arbiter #(
        .N_REQ  (N_REQ),
        .FLEN   (FLEN),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_res      (resp_res),
        .resp_error    (resp_error),
        .fu_up_valid   (fu_up_valid),
        .fu_a          (fu_a),
        .fu_b          (fu_b),
        .fu_res        (fu_res),
        .fu_down_valid (fu_down_valid),
        .fu_busy       (fu_busy),
        .fu_error      (fu_error),
        .err_unexpected(err_unexpected),
        .stat_issued   (stat_issued),
        .stat_stalled  (stat_stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FLEN-1:0] a_val(input int i);
        return 64'hA000_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [FLEN-1:0] b_val(input int i);
        return 64'hB000_0000_0000_1000 | 64'(i);
    endfunction

    function automatic logic [N_REQ-1:0] oh(input int i);
        return N_REQ'(1) << i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stat expectations only hold when the counters are built in.
    task automatic chk_stats(input string tag, input int issued, input int stalled);
`ifdef F_ADD_ARB_STATS_EN
        chk({tag, "_issued"}, 64'(stat_issued), 64'(issued));
        chk({tag, "_stalled"}, 64'(stat_stalled), 64'(stalled));
`else
        chk({tag, "_issued_tied"}, 64'(stat_issued), 64'(issued * 0));
        chk({tag, "_stalled_tied"}, 64'(stat_stalled), 64'(stalled * 0));
`endif
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    int fair_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst           = 1'b0;
        req_valid     = 4'b1111;
        fu_res        = '0;
        fu_down_valid = 1'b0;
        fu_busy       = 1'b0;
        fu_error      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*FLEN +: FLEN] = a_val(i);
            req_b[i*FLEN +: FLEN] = b_val(i);
        end

        // Reset: no grant while rst is low, registered outputs cleared.
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        tick();
        tick();
        chk("rst_ready2", 64'(req_ready), 64'h0);
        chk("rst_up_valid", 64'(fu_up_valid), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_error", 64'(resp_error), 64'h0);
        chk("rst_err_unexp", 64'(err_unexpected), 64'h0);
        chk_stats("rst", 0, 0);

        // Unexpected result right after reset.
        req_valid = '0;
        rst       = 1'b1;
        tick();
        fu_down_valid = 1'b1;
        fu_res        = 64'h1234;
        tick();
        fu_down_valid = 1'b0;
        chk("unexp_resp_valid", 64'(resp_valid), 64'h0);
        chk("unexp_err_set", 64'(err_unexpected), 64'h1);
        tick();
        tick();
        chk("unexp_err_held", 64'(err_unexpected), 64'h1);
        chk("unexp_resp_valid2", 64'(resp_valid), 64'h0);
        do_reset();
        chk("unexp_err_cleared", 64'(err_unexpected), 64'h0);

        // Single request from requester 0, result returned 4 cycles after issue.
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        #1;
        chk("single_up_valid", 64'(fu_up_valid), 64'h1);
        chk("single_fu_a", fu_a, a_val(0));
        chk("single_fu_b", fu_b, b_val(0));
        chk("single_ready_off", 64'(req_ready), 64'h0);
        tick();
        chk("single_up_valid_pulse", 64'(fu_up_valid), 64'h0);
        tick();
        tick();
        fu_down_valid = 1'b1;
        fu_res        = 64'h4010_0000_0000_0000;
        fu_error      = 1'b0;
        tick();
        fu_down_valid = 1'b0;
        chk("single_resp_valid", 64'(resp_valid), 64'h1);
        chk("single_resp_res", resp_res, 64'h4010_0000_0000_0000);
        chk("single_resp_error", 64'(resp_error), 64'h0);
        tick();
        chk("single_resp_pulse", 64'(resp_valid), 64'h0);
        chk_stats("single", 1, 0);

        // Fairness: all four requesting, grants rotate 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("fair_ready", 64'(req_ready), 64'(oh(fair_seq[k])));
            tick();
            chk("fair_up_valid", 64'(fu_up_valid), 64'h1);
            chk("fair_fu_a", fu_a, a_val(fair_seq[k]));
        end
        req_valid = '0;
        tick();
        chk("fair_up_valid_end", 64'(fu_up_valid), 64'h0);
        chk_stats("fair", 5, 0);
        // Results return in issue order to their owners; the third carries an error.
        for (int k = 0; k < 5; k++) begin
            fu_down_valid = 1'b1;
            fu_res        = 64'h3FF0_0000_0000_0000 + 64'(k);
            fu_error      = (k == 2);
            tick();
            chk("fair_resp_valid", 64'(resp_valid), 64'(oh(fair_seq[k])));
            chk("fair_resp_res", resp_res, 64'h3FF0_0000_0000_0000 + 64'(k));
            chk("fair_resp_error", 64'(resp_error), (k == 2) ? 64'h1 : 64'h0);
        end
        fu_down_valid = 1'b0;
        fu_error      = 1'b0;
        tick();
        chk("fair_resp_idle", 64'(resp_valid), 64'h0);
        chk("fair_no_unexp", 64'(err_unexpected), 64'h0);

        // Backpressure: unit busy for 3 cycles while requester 1 waits.
        do_reset();
        fu_busy   = 1'b1;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready_blocked", 64'(req_ready), 64'h0);
            tick();
            chk("bp_no_issue", 64'(fu_up_valid), 64'h0);
        end
        fu_busy = 1'b0;
        #1;
        chk("bp_ready_release", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        chk("bp_issue", 64'(fu_up_valid), 64'h1);
        chk("bp_fu_a", fu_a, a_val(1));
        chk_stats("bp", 1, 3);

        // Full: 8 issues from requester 0 with no returns.
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < MAX_OUT; k++) begin
            #1;
            chk("full_fill_ready", 64'(req_ready), 64'h1);
            tick();
        end
        req_valid = 4'b0100;
        #1;
        chk("full_blocked", 64'(req_ready), 64'h0);
        tick();
        chk("full_blocked2", 64'(req_ready), 64'h0);
        chk("full_no_issue", 64'(fu_up_valid), 64'h0);
        // A pop while full makes room for requester 2 in the same cycle.
        fu_down_valid = 1'b1;
        fu_res        = 64'h55;
        #1;
        chk("full_pop_grant", 64'(req_ready), 64'h4);
        tick();
        fu_down_valid = 1'b0;
        #1;
        chk("full_resp_head", 64'(resp_valid), 64'h1);
        chk("full_issue_r2", 64'(fu_up_valid), 64'h1);
        chk("full_fu_a_r2", fu_a, a_val(2));
        chk("full_still_full", 64'(req_ready), 64'h0);
        // Drain: seven tags for requester 0, then requester 2; count was exactly 8.
        req_valid = '0;
        for (int k = 0; k < MAX_OUT; k++) begin
            fu_down_valid = 1'b1;
            fu_res        = 64'h100 + 64'(k);
            tick();
            chk("full_drain_owner", 64'(resp_valid), (k < MAX_OUT - 1) ? 64'h1 : 64'h4);
        end
        fu_down_valid = 1'b0;
        tick();
        chk("full_drain_no_unexp", 64'(err_unexpected), 64'h0);
        fu_down_valid = 1'b1;
        tick();
        fu_down_valid = 1'b0;
        chk("full_extra_no_resp", 64'(resp_valid), 64'h0);
        chk("full_extra_unexp", 64'(err_unexpected), 64'h1);

        // Reset mid-flight with 3 outstanding operations.
        do_reset();
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mid_ready", 64'(req_ready), 64'(oh(k)));
            tick();
        end
        req_valid = 4'b1111;
        rst       = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        tick();
        rst       = 1'b1;
        req_valid = '0;
        chk("mid_up_valid", 64'(fu_up_valid), 64'h0);
        chk("mid_resp_valid", 64'(resp_valid), 64'h0);
        chk("mid_err_clear", 64'(err_unexpected), 64'h0);
        chk_stats("mid", 0, 0);
        fu_down_valid = 1'b1;
        tick();
        fu_down_valid = 1'b0;
        chk("mid_stale_no_resp", 64'(resp_valid), 64'h0);
        chk("mid_stale_unexp", 64'(err_unexpected), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
